// File: rtl/pill_line_pkg.sv
// Shared types and constants for the pill-bottle filling station controller.
package pill_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADVANCE = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_FILL    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_JAM      = 2'd1;
    localparam logic [1:0] FC_CONVEYOR = 2'd2;
    localparam logic [1:0] FC_LOST     = 2'd3;

    localparam logic [9:0] BOTTLEC_MAX = 10'd1023;

    function automatic logic [9:0] bottlec_sat_inc(input logic [9:0] v);
        logic [9:0] r;
        if (v == BOTTLEC_MAX) begin
            r = v;
        end else begin
            r = v + 10'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pill_line_ctrl_if.sv
// Operator/actuator signal bundle of the filling station controller.
// Optional batch_size field is present only when PILL_BATCH_LIMIT_EN is defined.
interface pill_line_ctrl_if;

    logic       start;
    logic       stop;
    logic       clr_fault;
    logic       clr_count;
    logic [5:0] pillc;
    logic       pill_pulse;
    logic       bottle_present;
`ifdef PILL_BATCH_LIMIT_EN
    logic [9:0] batch_size;
`endif
    logic       conveyor_on;
    logic       dispense_en;
    logic       bottle_done;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;
    logic [5:0] pills_now;
    logic [9:0] bottlec;

    modport slave (
`ifdef PILL_BATCH_LIMIT_EN
        input  batch_size,
`endif
        input  start, stop, clr_fault, clr_count, pillc, pill_pulse, bottle_present,
        output conveyor_on, dispense_en, bottle_done, busy, fault, fault_code,
               pills_now, bottlec
    );

    modport master (
`ifdef PILL_BATCH_LIMIT_EN
        output batch_size,
`endif
        output start, stop, clr_fault, clr_count, pillc, pill_pulse, bottle_present,
        input  conveyor_on, dispense_en, bottle_done, busy, fault, fault_code,
               pills_now, bottlec
    );

endinterface

// File: rtl/pill_line_timer.sv
// Clearable saturating up-counter with a terminal-compare flag against a
// caller-selected limit; shared by all timed states of the controller.
module pill_line_timer #(
    parameter int TMR_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [TMR_W-1:0] limit,
    output logic             hit
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // next count: clear has priority, otherwise count and hold at all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {TMR_W{1'b0}};
        end else if (count_q != {TMR_W{1'b1}}) begin
            count_d = count_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TMR_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == limit);

endmodule

// File: rtl/pill_line_ctrl.sv
// Filling-station sequencer: advance, settle, fill, release, with jam/conveyor/
// bottle-lost faults. Optional batch limit enabled by PILL_BATCH_LIMIT_EN.
module pill_line_ctrl
    import pill_line_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int JAM_TIMEOUT   = 1000,
    parameter int MOVE_TIMEOUT  = 5000,
    parameter int TMR_W         = 13
) (
    input  logic            clk,
    input  logic            rst,
    pill_line_ctrl_if.slave bus
);

    // timer counts from 0 on state entry, so a limit of N-1 means N cycles
    localparam logic [TMR_W-1:0] SETTLE_LIM = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] JAM_LIM    = TMR_W'(JAM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] MOVE_LIM   = TMR_W'(MOVE_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       start_q, start_d;
    logic [5:0] pillc_q, pillc_d;
    logic [5:0] pills_now_q, pills_now_d;
    logic       stop_pend_q, stop_pend_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       bottle_done_q, bottle_done_d;
    logic [9:0] bottlec_q, bottlec_d;
    logic       conveyor_on_q, conveyor_on_d;
    logic       dispense_en_q, dispense_en_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;
`ifdef PILL_BATCH_LIMIT_EN
    logic [9:0] batch_q, batch_d;
    logic [9:0] run_cnt_q, run_cnt_d;
    logic       batch_end_s;
`endif

    logic             start_edge_s;
    logic             pill_cnt_s;
    logic             done_s;
    logic             tmr_clr_s;
    logic             tmr_hit_s;
    logic [TMR_W-1:0] tmr_limit_s;

    assign start_edge_s = bus.start & ~start_q;

    pill_line_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .rst_n (rst),
        .clr   (tmr_clr_s),
        .limit (tmr_limit_s),
        .hit   (tmr_hit_s)
    );

    // timeout threshold for the current state
    always_comb begin
        tmr_limit_s = MOVE_LIM;
        case (state_q)
            ST_SETTLE: tmr_limit_s = SETTLE_LIM;
            ST_FILL:   tmr_limit_s = JAM_LIM;
            default:   tmr_limit_s = MOVE_LIM;
        endcase
    end

    // next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        start_d      = bus.start;
        pillc_d      = pillc_q;
        pills_now_d  = pills_now_q;
        stop_pend_d  = stop_pend_q;
        fault_code_d = fault_code_q;
        pill_cnt_s   = 1'b0;
        done_s       = 1'b0;
`ifdef PILL_BATCH_LIMIT_EN
        batch_d      = batch_q;
        run_cnt_d    = run_cnt_q;
        batch_end_s  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s && (bus.pillc != 6'd0)) begin
                    state_d     = ST_ADVANCE;
                    pillc_d     = bus.pillc;
                    pills_now_d = 6'd0;
                    stop_pend_d = 1'b0;
`ifdef PILL_BATCH_LIMIT_EN
                    batch_d     = bus.batch_size;
                    run_cnt_d   = 10'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADVANCE: begin
                if (tmr_hit_s) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_CONVEYOR;
                end else if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.bottle_present) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_SETTLE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (!bus.bottle_present) begin
                    state_d = ST_ADVANCE;
                end else if (tmr_hit_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_FILL: begin
                // a stop during filling only takes effect once the bottle is released
                stop_pend_d = stop_pend_q | bus.stop;
                if (!bus.bottle_present) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_LOST;
                end else if (bus.pill_pulse) begin
                    pill_cnt_s  = 1'b1;
                    pills_now_d = pills_now_q + 6'd1;
                    if ((pills_now_q + 6'd1) == pillc_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (tmr_hit_s) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_JAM;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RELEASE: begin
                stop_pend_d = stop_pend_q | bus.stop;
                if (tmr_hit_s) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_CONVEYOR;
                end else if (!bus.bottle_present) begin
                    done_s      = 1'b1;
                    pills_now_d = 6'd0;
`ifdef PILL_BATCH_LIMIT_EN
                    if (run_cnt_q != 10'h3FF) begin
                        run_cnt_d = run_cnt_q + 10'd1;
                    end else begin
                        run_cnt_d = run_cnt_q;
                    end
                    batch_end_s = (batch_q != 10'd0) && (run_cnt_d == batch_q);
                    if (stop_pend_q || bus.stop || batch_end_s) begin
`else
                    if (stop_pend_q || bus.stop) begin
`endif
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                    pills_now_d  = 6'd0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                fault_code_d = FC_NONE;
                pills_now_d  = 6'd0;
            end
        endcase
    end

    // timer restarts on any state change, each counted pill, and while parked
    always_comb begin
        tmr_clr_s = (state_d != state_q) || pill_cnt_s ||
                    (state_q == ST_IDLE) || (state_q == ST_FAULT);
    end

    // output and counter next values, decoded from the upcoming state
    always_comb begin
        conveyor_on_d = (state_d == ST_ADVANCE) || (state_d == ST_RELEASE);
        dispense_en_d = (state_d == ST_FILL);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        fault_d       = (state_d == ST_FAULT);
        bottle_done_d = done_s;
        if (bus.clr_count) begin
            bottlec_d = 10'd0;
        end else if (done_s) begin
            bottlec_d = bottlec_sat_inc(bottlec_q);
        end else begin
            bottlec_d = bottlec_q;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            pillc_q       <= 6'd0;
            pills_now_q   <= 6'd0;
            stop_pend_q   <= 1'b0;
            fault_code_q  <= FC_NONE;
            bottle_done_q <= 1'b0;
            bottlec_q     <= 10'd0;
            conveyor_on_q <= 1'b0;
            dispense_en_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
`ifdef PILL_BATCH_LIMIT_EN
            batch_q       <= 10'd0;
            run_cnt_q     <= 10'd0;
`endif
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            pillc_q       <= pillc_d;
            pills_now_q   <= pills_now_d;
            stop_pend_q   <= stop_pend_d;
            fault_code_q  <= fault_code_d;
            bottle_done_q <= bottle_done_d;
            bottlec_q     <= bottlec_d;
            conveyor_on_q <= conveyor_on_d;
            dispense_en_q <= dispense_en_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
`ifdef PILL_BATCH_LIMIT_EN
            batch_q       <= batch_d;
            run_cnt_q     <= run_cnt_d;
`endif
        end
    end

    assign bus.conveyor_on = conveyor_on_q;
    assign bus.dispense_en = dispense_en_q;
    assign bus.bottle_done = bottle_done_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;
    assign bus.pills_now   = pills_now_q;
    assign bus.bottlec     = bottlec_q;

endmodule

// File: doc/pill_line_ctrl.md
Name: pill_line_ctrl

Overview:
Sequencing controller for the pill-bottle filling station. It advances the conveyor until a bottle is present and lets it settle. It then enables the dispenser and counts pill-sensor pulses up to the programmed pills-per-bottle. Finally it releases the bottle and tallies filled bottles, with jam/timeout fault detection. It sits between the operator inputs (start, stop, pillc) and the conveyor/dispenser actuators.

Parameters:
SETTLE_CYCLES, 8, cycles bottle_present must stay high before filling
JAM_TIMEOUT, 1000, max cycles between pill pulses in FILL before jam fault
MOVE_TIMEOUT, 5000, max cycles in ADVANCE or RELEASE before conveyor fault
TMR_W, 13, timer width; must hold max(SETTLE_CYCLES, JAM_TIMEOUT, MOVE_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  level; 0->1 edge (registered) accepted in IDLE only
stop  in  1  level; request to stop the run
clr_fault  in  1  single-cycle; leaves FAULT
clr_count  in  1  single-cycle; clears bottlec
pillc  in  6  pills per bottle; latched on start acceptance
pill_pulse  in  1  one-cycle pulse per pill dropped (synchronous to clk)
bottle_present  in  1  bottle in fill position
conveyor_on  out  1  conveyor motor enable
dispense_en  out  1  dispenser enable
bottle_done  out  1  one-cycle pulse per completed bottle
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  high in FAULT
fault_code  out  2  0 none, 1 jam, 2 conveyor timeout, 3 bottle lost
pills_now  out  6  pills counted into the current bottle
bottlec  out  10  bottles filled; saturates at 1023

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched pillc, timer and start-edge register cleared.
- All outputs are registered, so an output responds one cycle after the state/event that causes it.
- IDLE: start edge with pillc!=0 -> latch pillc, pills_now=0, go ADVANCE. Start edge with pillc==0 is ignored. Start while high (no edge) is ignored.
- ADVANCE: conveyor_on=1; timer counts.
  - bottle_present=1 -> SETTLE, timer=0.
  - Timer reaches MOVE_TIMEOUT -> FAULT, code 2.
  - stop=1 -> IDLE.
- SETTLE: conveyor_on=0.
  - bottle_present=0 -> back to ADVANCE.
  - bottle_present held SETTLE_CYCLES cycles -> FILL.
  - stop=1 -> IDLE.
- FILL: dispense_en=1.
  - Each pill_pulse increments pills_now and restarts the jam timer.
  - When pills_now+1 == latched pillc on a pulse -> RELEASE; dispense_en low the next cycle.
  - Jam timer reaches JAM_TIMEOUT -> FAULT, code 1.
  - bottle_present=0 -> FAULT, code 3 (bottle lost wins over jam in the same cycle).
  - stop is recorded as a pending flag; it does not abort the fill.
- RELEASE: conveyor_on=1, dispense_en=0.
  - bottle_present=0 -> one-cycle bottle_done, bottlec++ (saturating), pills_now=0.
  - Then IDLE if stop is pending or stop is currently high; otherwise ADVANCE.
  - Timer reaches MOVE_TIMEOUT -> FAULT, code 2.
- pill_pulse outside FILL: ignored (not counted).
- FAULT: conveyor_on=0, dispense_en=0, fault=1, fault_code held. clr_fault -> IDLE, fault_code=0, pills_now=0. start is ignored in FAULT.
- clr_count: clears bottlec in any state. If coincident with an increment, the clear wins.
- pillc changes mid-run have no effect until the next start acceptance.

Optional Feature:
PILL_BATCH_LIMIT_EN
- With the macro: adds input batch_size[9:0] (latched at start) and a run counter cleared at start. After the bottle_done where the run count equals batch_size, go IDLE. batch_size==0 means unlimited.
- Without the macro: the port is absent and the run continues until stop or fault.

Decomposition:
- Package pill_line_pkg: state enum (IDLE, ADVANCE, SETTLE, FILL, RELEASE, FAULT), fault_code constants, bottlec saturation value 1023.
- Sub-module pill_line_timer: clearable up-counter of width TMR_W with a terminal-compare output. One instance is shared across states and cleared on every state change and on every counted pill.

Test Plan:
1. pillc=3, start edge, bottle_present rises after 4 cycles, 3 pill pulses, bottle leaves -> bottle_done once, bottlec=1, state returns to ADVANCE.
2. pillc=0, start edge -> stays IDLE, busy=0, conveyor_on=0.
3. In FILL with pills_now=1, no pulse for JAM_TIMEOUT cycles -> fault=1, fault_code=1, dispense_en=0; clr_fault -> IDLE, fault=0.
4. stop asserted in FILL with pillc=2 -> fill completes, bottle_done pulses, then IDLE with busy=0.
5. bottle_present drops during SETTLE -> back to ADVANCE with conveyor_on=1. Same drop during FILL -> fault_code=3.
6. rst low mid-FILL -> all outputs 0 immediately. bottlec=1023 plus one more bottle -> bottlec stays 1023. Coincident clr_count and bottle_done -> bottlec=0.
